tictactoe_game_fsm: RTL and testbench

//  Game sequencer for the 3x3 tic-tac-toe VGA display. Takes debounced single-cycle button pulses,

---
 rtl/tictactoe_pkg.sv | 64 ++++++
 rtl/tictactoe_win_check.sv | 42 ++++
 rtl/tictactoe_game_fsm.sv | 206 ++++++++++++++++++++
 tb/tb_tictactoe_game_fsm.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe game sequencer.
// Cell encoding, FSM state encoding, screen geometry of the 3x3 grid,
// the eight winning-line masks and a few small lookup helpers.
package tictactoe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    X     = 2'b01,
    O     = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    ST_TURN  = 2'd0,
    ST_CHECK = 2'd1,
    ST_WIN   = 2'd2,
    ST_DRAW  = 2'd3
  } state_t;

  // Result codes shown to the renderer
  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_X    = 2'b01;
  localparam logic [1:0] RES_O    = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  // Grid edges on a 640x480 screen; element k is the left/top edge of column/row k,
  // element 3 closes the last cell.
  localparam logic [3:0][15:0] COL_EDGE = {16'd640, 16'd426, 16'd213, 16'd0};
  localparam logic [3:0][9:0]  ROW_EDGE = {10'd480, 10'd320, 10'd160, 10'd0};

  // Winning lines as 9-bit cell masks (bit i = cell i, row-major):
  // rows 0..2, columns 0..2, main diagonal, anti-diagonal.
  localparam logic [7:0][8:0] WIN_LINES = {
    9'b001_010_100,  // cells 2,4,6
    9'b100_010_001,  // cells 0,4,8
    9'b100_100_100,  // column 2
    9'b010_010_010,  // column 1
    9'b001_001_001,  // column 0
    9'b111_000_000,  // row 2
    9'b000_111_000,  // row 1
    9'b000_000_111   // row 0
  };

  // Row of a cell index 0..8
  function automatic logic [1:0] cellRow(input logic [3:0] idx);
    if (idx >= 4'd6) return 2'd2;
    else if (idx >= 4'd3) return 2'd1;
    else return 2'd0;
  endfunction

  // Column of a cell index 0..8
  function automatic logic [1:0] cellCol(input logic [3:0] idx);
    case (idx)
      4'd1, 4'd4, 4'd7: return 2'd1;
      4'd2, 4'd5, 4'd8: return 2'd2;
      default:          return 2'd0;
    endcase
  endfunction

  // Mark placed by the player whose turn it is (turnIsO = low bit of who)
  function automatic logic [1:0] markOf(input logic turnIsO);
    return turnIsO ? 2'(O) : 2'(X);
  endfunction

endpackage

// File: rtl/tictactoe_win_check.sv
// Combinational board evaluator: flags completed lines for each player,
// builds the union mask of all completed lines and reports a full board.
module tictactoe_win_check
  import tictactoe_pkg::*;
(
  input  logic [17:0] board,
  output logic [8:0]  line_mask,
  output logic        x_win,
  output logic        o_win,
  output logic        full
);

  logic [8:0] cellX;
  logic [8:0] cellO;
  logic [7:0] lineX;
  logic [7:0] lineO;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : gCell
      assign cellX[gi] = (board[2*gi +: 2] == X);
      assign cellO[gi] = (board[2*gi +: 2] == O);
    end
    for (gi = 0; gi < 8; gi++) begin : gLine
      assign lineX[gi] = ((cellX & WIN_LINES[gi]) == WIN_LINES[gi]);
      assign lineO[gi] = ((cellO & WIN_LINES[gi]) == WIN_LINES[gi]);
    end
  endgenerate

  // Union of every completed line, so double wins light all their cells
  always_comb begin
    line_mask = '0;
    for (int i = 0; i < 8; i++) begin
      if (lineX[i] || lineO[i]) line_mask = line_mask | WIN_LINES[i];
    end
  end

  assign x_win = |lineX;
  assign o_win = |lineO;
  assign full  = &(cellX | cellO);

endmodule

// File: rtl/tictactoe_game_fsm.sv
// Tic-tac-toe game sequencer: board, cursor and turn ownership, win/draw
// detection and the selected-square rectangle for the VGA renderer.
// Optional feature: define TURN_TIMER_EN to enable the per-turn time limit
// with auto-placement after TURN_CYCLES idle cycles.
module tictactoe_game_fsm
  import tictactoe_pkg::*;
#(
  parameter int unsigned TURN_CYCLES  = 250_000_000,
  parameter bit          FIRST_PLAYER = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        move_pulse,
  input  logic        select_pulse,
  input  logic        restart_pulse,
  output logic [17:0] board,
  output logic [1:0]  who,
  output logic [3:0]  cursor,
  output logic [15:0] selected_square_startX,
  output logic [15:0] selected_square_endX,
  output logic [9:0]  selected_square_startY,
  output logic [9:0]  selected_square_endY,
  output logic [8:0]  winner_play,
  output logic        game_over,
  output logic [1:0]  result
);

  localparam logic [1:0] S_TURN  = ST_TURN;
  localparam logic [1:0] S_CHECK = ST_CHECK;
  localparam logic [1:0] S_WIN   = ST_WIN;
  localparam logic [1:0] S_DRAW  = ST_DRAW;

  logic [1:0]  stateReg;
  logic [1:0]  stateNext;
  logic [17:0] boardNext;
  logic [1:0]  whoNext;
  logic [3:0]  cursorNext;
  logic [8:0]  winnerNext;
  logic        gameOverNext;
  logic [1:0]  resultNext;

  logic [8:0]  lineMask;
  logic        xWin;
  logic        oWin;
  logic        boardFull;

  logic [1:0]  cursorCell;
  logic        cursorEmpty;
  logic [3:0]  firstEmpty;
  logic        timerExpired;
  logic        doPlace;
  logic [3:0]  placeIdx;
  logic [1:0]  cursorRow;
  logic [1:0]  cursorCol;

  tictactoe_win_check uWinCheck (
    .board     (board),
    .line_mask (lineMask),
    .x_win     (xWin),
    .o_win     (oWin),
    .full      (boardFull)
  );

  // Contents of the cell under the cursor and lowest-index empty cell
  always_comb begin
    cursorCell = EMPTY;
    firstEmpty = '0;
    for (int i = 0; i < 9; i++) begin
      if (cursor == 4'(i)) cursorCell = board[2*i +: 2];
    end
    for (int i = 8; i >= 0; i--) begin
      if (board[2*i +: 2] == EMPTY) firstEmpty = 4'(i);
    end
  end

  assign cursorEmpty = (cursorCell == EMPTY);

`ifdef TURN_TIMER_EN
  localparam int TIMER_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
  logic [TIMER_W-1:0] timerReg;

  assign timerExpired = (stateReg == S_TURN) && (timerReg == TIMER_W'(TURN_CYCLES - 1));

  // Turn timer: counts only while waiting in S_TURN, held at zero elsewhere so
  // every entry into S_TURN starts a fresh turn
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timerReg <= '0;
    end else if (restart_pulse || stateReg != S_TURN || doPlace) begin
      timerReg <= '0;
    end else begin
      timerReg <= timerReg + 1'b1;
    end
  end
`else
  logic unusedTurnCycles;
  assign unusedTurnCycles = ^TURN_CYCLES;
  assign timerExpired     = 1'b0;
`endif

  // Placement decision: a valid select places at the cursor; otherwise an
  // expired turn places at the cursor if free, else at the lowest empty cell
  always_comb begin
    doPlace  = 1'b0;
    placeIdx = cursor;
    if (stateReg == S_TURN) begin
      if (select_pulse && cursorEmpty) begin
        doPlace = 1'b1;
      end else if (timerExpired) begin
        doPlace  = 1'b1;
        placeIdx = cursorEmpty ? cursor : firstEmpty;
      end
    end
  end

  // Next-state and output-register logic; restart overrides everything
  always_comb begin
    stateNext    = stateReg;
    boardNext    = board;
    whoNext      = who;
    cursorNext   = cursor;
    winnerNext   = winner_play;
    gameOverNext = game_over;
    resultNext   = result;
    if (restart_pulse) begin
      stateNext    = S_TURN;
      boardNext    = '0;
      whoNext      = {1'b0, FIRST_PLAYER};
      cursorNext   = '0;
      winnerNext   = '0;
      gameOverNext = 1'b0;
      resultNext   = RES_NONE;
    end else begin
      case (stateReg)
        S_TURN: begin
          if (doPlace) begin
            for (int i = 0; i < 9; i++) begin
              if (placeIdx == 4'(i)) boardNext[2*i +: 2] = markOf(who[0]);
            end
            stateNext = S_CHECK;
          end else if (move_pulse) begin
            cursorNext = (cursor == 4'd8) ? 4'd0 : cursor + 4'd1;
          end
        end
        S_CHECK: begin
          if (xWin || oWin) begin
            winnerNext   = lineMask;
            resultNext   = who[0] ? RES_O : RES_X;
            gameOverNext = 1'b1;
            stateNext    = S_WIN;
          end else if (boardFull) begin
            resultNext   = RES_DRAW;
            gameOverNext = 1'b1;
            stateNext    = S_DRAW;
          end else begin
            whoNext   = {1'b0, ~who[0]};
            stateNext = S_TURN;
          end
        end
        default: begin
          // S_WIN / S_DRAW: everything frozen until restart
        end
      endcase
    end
  end

  // Game state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg    <= S_TURN;
      board       <= '0;
      who         <= {1'b0, FIRST_PLAYER};
      cursor      <= '0;
      winner_play <= '0;
      game_over   <= 1'b0;
      result      <= RES_NONE;
    end else begin
      stateReg    <= stateNext;
      board       <= boardNext;
      who         <= whoNext;
      cursor      <= cursorNext;
      winner_play <= winnerNext;
      game_over   <= gameOverNext;
      result      <= resultNext;
    end
  end

  assign cursorRow = cellRow(cursor);
  assign cursorCol = cellCol(cursor);

  // Selected-square rectangle, registered from the cursor register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      selected_square_startX <= COL_EDGE[0];
      selected_square_endX   <= COL_EDGE[1];
      selected_square_startY <= ROW_EDGE[0];
      selected_square_endY   <= ROW_EDGE[1];
    end else begin
      selected_square_startX <= COL_EDGE[cursorCol];
      selected_square_endX   <= COL_EDGE[cursorCol + 2'd1];
      selected_square_startY <= ROW_EDGE[cursorRow];
      selected_square_endY   <= ROW_EDGE[cursorRow + 2'd1];
    end
  end

endmodule

// File: tb/tb_tictactoe_game_fsm.sv
// Testbench for tictactoe_game_fsm: table of pulse vectors with hand-computed
// expected board/turn/cursor/result, plus hand-written multi-cycle sequences.
// The turn-timer sequence runs only when TURN_TIMER_EN is defined.
module tb_tictactoe_game_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        move_pulse = 1'b0;
  logic        select_pulse = 1'b0;
  logic        restart_pulse = 1'b0;
  logic [17:0] board;
  logic [1:0]  who;
  logic [3:0]  cursor;
  logic [15:0] selected_square_startX;
  logic [15:0] selected_square_endX;
  logic [9:0]  selected_square_startY;
  logic [9:0]  selected_square_endY;
  logic [8:0]  winner_play;
  logic        game_over;
  logic [1:0]  result;

  tictactoe_game_fsm #(
    .TURN_CYCLES  (16),
    .FIRST_PLAYER (1'b0)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .move_pulse             (move_pulse),
    .select_pulse           (select_pulse),
    .restart_pulse          (restart_pulse),
    .board                  (board),
    .who                    (who),
    .cursor                 (cursor),
    .selected_square_startX (selected_square_startX),
    .selected_square_endX   (selected_square_endX),
    .selected_square_startY (selected_square_startY),
    .selected_square_endY   (selected_square_endY),
    .winner_play            (winner_play),
    .game_over              (game_over),
    .result                 (result)
  );

  always #5 clk = ~clk;

  int testsRun = 0;
  int testsFailed = 0;

  int colE[4] = '{0, 213, 426, 640};
  int rowE[4] = '{0, 160, 320, 480};

  typedef struct {
    logic       mv;
    logic       sel;
    logic       rs;
    int         n;
    logic [8:0] xs;
    logic [8:0] os;
    logic [1:0] who;
    logic [3:0] cur;
    logic [8:0] win;
    logic       over;
    logic [1:0] res;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [17:0] mkBoard(input logic [8:0] xs, input logic [8:0] os);
    logic [17:0] b;
    b = '0;
    for (int i = 0; i < 9; i++) begin
      if (xs[i]) b[2*i +: 2] = 2'b01;
      else if (os[i]) b[2*i +: 2] = 2'b10;
    end
    return b;
  endfunction

  function automatic vec_t mkVec(input logic mv, input logic sel, input logic rs, input int n,
                                 input logic [8:0] xs, input logic [8:0] os, input logic [1:0] w,
                                 input logic [3:0] cur, input logic [8:0] win, input logic over,
                                 input logic [1:0] res);
    vec_t v;
    v.mv = mv; v.sel = sel; v.rs = rs; v.n = n; v.xs = xs; v.os = os;
    v.who = w; v.cur = cur; v.win = win; v.over = over; v.res = res;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [8:0] xs, input logic [8:0] os,
                          input logic [1:0] w, input logic [3:0] cur, input logic [8:0] win,
                          input logic over, input logic [1:0] res);
    int r;
    int c;
    r = int'(cur) / 3;
    c = int'(cur) % 3;
    check({tag, ".board"},  32'(board),       32'(mkBoard(xs, os)));
    check({tag, ".who"},    32'(who),         32'(w));
    check({tag, ".cursor"}, 32'(cursor),      32'(cur));
    check({tag, ".win"},    32'(winner_play), 32'(win));
    check({tag, ".over"},   32'(game_over),   32'(over));
    check({tag, ".result"}, 32'(result),      32'(res));
    check({tag, ".sx"},     32'(selected_square_startX), 32'(colE[c]));
    check({tag, ".ex"},     32'(selected_square_endX),   32'(colE[c+1]));
    check({tag, ".sy"},     32'(selected_square_startY), 32'(rowE[r]));
    check({tag, ".ey"},     32'(selected_square_endY),   32'(rowE[r+1]));
  endtask

  // Called at a negedge: pulses the inputs for n cycles, one idle cycle, then checks
  task automatic applyVec(input int idx, input vec_t v);
    for (int k = 0; k < v.n; k++) begin
      move_pulse    = v.mv;
      select_pulse  = v.sel;
      restart_pulse = v.rs;
      @(posedge clk);
      @(negedge clk);
    end
    move_pulse    = 1'b0;
    select_pulse  = 1'b0;
    restart_pulse = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkAll($sformatf("vec%0d", idx), v.xs, v.os, v.who, v.cur, v.win, v.over, v.res);
    $display("[TB] vec%0d mv=%0d sel=%0d rs=%0d n=%0d -> board=%h who=%0d cursor=%0d result=%0d",
             idx, v.mv, v.sel, v.rs, v.n, board, who, cursor, result);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Test 1: reset, then four moves
    vecs.push_back(mkVec(1,0,0,4, 9'h000,9'h000,2'd0,4'd4, 9'h000,0,2'b00));
    vecs.push_back(mkVec(0,0,1,1, 9'h000,9'h000,2'd0,4'd0, 9'h000,0,2'b00));
    // Test 2: X wins row 0 via cells 0,3,1,4,2
    vecs.push_back(mkVec(0,1,0,1, 9'h001,9'h000,2'd1,4'd0, 9'h000,0,2'b00));
    vecs.push_back(mkVec(1,0,0,3, 9'h001,9'h000,2'd1,4'd3, 9'h000,0,2'b00));
    vecs.push_back(mkVec(0,1,0,1, 9'h001,9'h008,2'd0,4'd3, 9'h000,0,2'b00));
    vecs.push_back(mkVec(1,0,0,7, 9'h001,9'h008,2'd0,4'd1, 9'h000,0,2'b00));
    vecs.push_back(mkVec(0,1,0,1, 9'h003,9'h008,2'd1,4'd1, 9'h000,0,2'b00));
    vecs.push_back(mkVec(1,0,0,3, 9'h003,9'h008,2'd1,4'd4, 9'h000,0,2'b00));
    vecs.push_back(mkVec(0,1,0,1, 9'h003,9'h018,2'd0,4'd4, 9'h000,0,2'b00));
    vecs.push_back(mkVec(1,0,0,7, 9'h003,9'h018,2'd0,4'd2, 9'h000,0,2'b00));
    vecs.push_back(mkVec(0,1,0,1, 9'h007,9'h018,2'd0,4'd2, 9'h007,1,2'b01));
    vecs.push_back(mkVec(1,0,0,1, 9'h007,9'h018,2'd0,4'd2, 9'h007,1,2'b01));
    vecs.push_back(mkVec(0,1,0,1, 9'h007,9'h018,2'd0,4'd2, 9'h007,1,2'b01));
    vecs.push_back(mkVec(0,0,1,1, 9'h000,9'h000,2'd0,4'd0, 9'h000,0,2'b00));
    // Test 3: select on occupied cell ignored
    vecs.push_back(mkVec(1,0,0,4, 9'h000,9'h000,2'd0,4'd4, 9'h000,0,2'b00));
    vecs.push_back(mkVec(0,1,0,1, 9'h010,9'h000,2'd1,4'd4, 9'h000,0,2'b00));
    vecs.push_back(mkVec(0,1,0,1, 9'h010,9'h000,2'd1,4'd4, 9'h000,0,2'b00));
    vecs.push_back(mkVec(1,0,0,1, 9'h010,9'h000,2'd1,4'd5, 9'h000,0,2'b00));
    vecs.push_back(mkVec(0,1,0,1, 9'h010,9'h020,2'd0,4'd5, 9'h000,0,2'b00));
    vecs.push_back(mkVec(0,0,1,1, 9'h000,9'h000,2'd0,4'd0, 9'h000,0,2'b00));
    // Test 4: draw via 0,1,2,4,3,5,7,6,8
    vecs.push_back(mkVec(0,1,0,1, 9'h001,9'h000,2'd1,4'd0, 9'h000,0,2'b00));
    vecs.push_back(mkVec(1,0,0,1, 9'h001,9'h000,2'd1,4'd1, 9'h000,0,2'b00));
    vecs.push_back(mkVec(0,1,0,1, 9'h001,9'h002,2'd0,4'd1, 9'h000,0,2'b00));
    vecs.push_back(mkVec(1,0,0,1, 9'h001,9'h002,2'd0,4'd2, 9'h000,0,2'b00));
    vecs.push_back(mkVec(0,1,0,1, 9'h005,9'h002,2'd1,4'd2, 9'h000,0,2'b00));
    vecs.push_back(mkVec(1,0,0,2, 9'h005,9'h002,2'd1,4'd4, 9'h000,0,2'b00));
    vecs.push_back(mkVec(0,1,0,1, 9'h005,9'h012,2'd0,4'd4, 9'h000,0,2'b00));
    vecs.push_back(mkVec(1,0,0,8, 9'h005,9'h012,2'd0,4'd3, 9'h000,0,2'b00));
    vecs.push_back(mkVec(0,1,0,1, 9'h00D,9'h012,2'd1,4'd3, 9'h000,0,2'b00));
    vecs.push_back(mkVec(1,0,0,2, 9'h00D,9'h012,2'd1,4'd5, 9'h000,0,2'b00));
    vecs.push_back(mkVec(0,1,0,1, 9'h00D,9'h032,2'd0,4'd5, 9'h000,0,2'b00));
    vecs.push_back(mkVec(1,0,0,2, 9'h00D,9'h032,2'd0,4'd7, 9'h000,0,2'b00));
    vecs.push_back(mkVec(0,1,0,1, 9'h08D,9'h032,2'd1,4'd7, 9'h000,0,2'b00));
    vecs.push_back(mkVec(1,0,0,8, 9'h08D,9'h032,2'd1,4'd6, 9'h000,0,2'b00));
    vecs.push_back(mkVec(0,1,0,1, 9'h08D,9'h072,2'd0,4'd6, 9'h000,0,2'b00));
    vecs.push_back(mkVec(1,0,0,2, 9'h08D,9'h072,2'd0,4'd8, 9'h000,0,2'b00));
    vecs.push_back(mkVec(0,1,0,1, 9'h18D,9'h072,2'd0,4'd8, 9'h000,1,2'b11));
    vecs.push_back(mkVec(1,0,0,1, 9'h18D,9'h072,2'd0,4'd8, 9'h000,1,2'b11));
    vecs.push_back(mkVec(0,0,1,1, 9'h000,9'h000,2'd0,4'd0, 9'h000,0,2'b00));
    // Test 5: cursor wrap, then move+select in the same cycle
    vecs.push_back(mkVec(1,0,0,8, 9'h000,9'h000,2'd0,4'd8, 9'h000,0,2'b00));
    vecs.push_back(mkVec(1,0,0,1, 9'h000,9'h000,2'd0,4'd0, 9'h000,0,2'b00));
    vecs.push_back(mkVec(1,0,0,2, 9'h000,9'h000,2'd0,4'd2, 9'h000,0,2'b00));
    vecs.push_back(mkVec(1,1,0,1, 9'h004,9'h000,2'd1,4'd2, 9'h000,0,2'b00));

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAll("reset_held", 9'h000, 9'h000, 2'd0, 4'd0, 9'h000, 1'b0, 2'b00);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkAll("reset_released", 9'h000, 9'h000, 2'd0, 4'd0, 9'h000, 1'b0, 2'b00);
    $display("[TB] reset: board=%h who=%0d cursor=%0d", board, who, cursor);

    foreach (vecs[i]) applyVec(i, vecs[i]);

    // Select latency: board at N+1, turn toggles at N+2
    restart_pulse = 1'b1;
    @(posedge clk);
    @(negedge clk);
    restart_pulse = 1'b0;
    select_pulse  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    select_pulse = 1'b0;
    check("lat_board_n1", 32'(board), 32'(mkBoard(9'h001, 9'h000)));
    check("lat_who_n1",   32'(who),   32'd0);
    @(posedge clk);
    @(negedge clk);
    check("lat_who_n2",   32'(who),   32'd1);
    $display("[TB] latency: board=%h who=%0d", board, who);

    // Restart has priority over move and select in the same cycle
    restart_pulse = 1'b1;
    move_pulse    = 1'b1;
    select_pulse  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    restart_pulse = 1'b0;
    move_pulse    = 1'b0;
    select_pulse  = 1'b0;
    check("restart_prio_board",  32'(board),  32'd0);
    check("restart_prio_cursor", 32'(cursor), 32'd0);
    check("restart_prio_who",    32'(who),    32'd0);
    $display("[TB] restart priority: board=%h cursor=%0d", board, cursor);

    // Async reset during a pending select: no placement survives
    select_pulse = 1'b1;
    #2 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    select_pulse = 1'b0;
    check("rst_abort_board", 32'(board), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_abort_board_after", 32'(board), 32'd0);
    check("rst_abort_who",         32'(who),   32'd0);
    $display("[TB] reset abort: board=%h who=%0d", board, who);

`ifdef TURN_TIMER_EN
    // X takes cell 0; O then idles with the cursor on the occupied cell 0
    restart_pulse = 1'b1;
    @(posedge clk);
    @(negedge clk);
    restart_pulse = 1'b0;
    select_pulse  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    select_pulse = 1'b0;
    @(posedge clk);
    @(negedge clk);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("timer_before_expiry", 32'(board), 32'(mkBoard(9'h001, 9'h000)));
    @(posedge clk);
    @(negedge clk);
    check("timer_autoplace", 32'(board), 32'(mkBoard(9'h001, 9'h002)));
    $display("[TB] timer autoplace: board=%h", board);
    repeat (6) @(posedge clk);
    @(negedge clk);
    restart_pulse = 1'b1;
    @(posedge clk);
    @(negedge clk);
    restart_pulse = 1'b0;
    check("timer_restart_board", 32'(board), 32'd0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("timer_restart_hold", 32'(board), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("timer_restart_place", 32'(board), 32'(mkBoard(9'h001, 9'h000)));
    $display("[TB] timer after restart: board=%h", board);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
